// File: rtl/vend_coin_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vend_coin_sequencer_if : acceptor/core-side signal bundle for the        |
// | coin sequencer.                                       Rev 1.0            |
// +--------------------------------------------------------------------------+
interface vend_coin_sequencer_if #(
   parameter int FIFO_DEPTH = 4,
   parameter int STOCK_W    = 8
) ();
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic               one_req;
   logic               two_req;
   logic               choco_done;
   logic               load_en;
   logic [STOCK_W-1:0] load_val;
   logic               one_in;
   logic               two_in;
   logic [1:0]         coin_reject;
   logic               refund_one;
   logic               refund_two;
   logic               sold_out;
   logic [CNT_W-1:0]   fifo_count;
   logic [7:0]         vend_count;

   modport slave (
      input  one_req, two_req, choco_done, load_en, load_val,
      output one_in, two_in, coin_reject, refund_one, refund_two,
             sold_out, fifo_count, vend_count
   );

   modport master (
      output one_req, two_req, choco_done, load_en, load_val,
      input  one_in, two_in, coin_reject, refund_one, refund_two,
             sold_out, fifo_count, vend_count
   );
endinterface
`default_nettype wire

// File: rtl/vend_coin_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vend_coin_sequencer : buffers coin strobes, issues spaced coin pulses,   |
// | tracks stock and refunds buffered coins on sell-out.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module vend_coin_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ISSUE_GAP  = 2,
   parameter int STOCK_W    = 8,
   parameter int INIT_STOCK = 10
) (
   input  wire logic               clk,
   input  wire logic               reset,
   vend_coin_sequencer_if.slave    bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int GAP_W = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP - 1) : 1;
   localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(ISSUE_GAP - 2);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GAP    = 2'd1,
      S_REFUND = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [FIFO_DEPTH-1:0] r_fifo;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [GAP_W-1:0]      r_gap_cnt;
   logic [STOCK_W-1:0]    r_stock;
   logic [7:0]            r_vend;
   logic                  r_one_in;
   logic                  r_two_in;
   logic                  r_refund_one;
   logic                  r_refund_two;
   logic [1:0]            r_reject;

   logic                  w_empty;
   logic                  w_stock_zero;
   logic                  w_head;
   logic                  w_pop;
   logic                  w_issue;
   logic                  w_refund;
   logic                  w_accept;
   logic [CNT_W-1:0]      w_free;
   logic                  w_push_two;
   logic                  w_push_one;
   logic [PTR_W-1:0]      w_one_slot;

   assign w_empty      = (r_count == '0);
   assign w_stock_zero = (r_stock == '0);
   assign w_head       = r_fifo[r_rd_ptr];

   // Free space is judged before any same-cycle pop; two-unit coin claims a slot first.
   assign w_accept   = (r_state != S_REFUND) && !w_stock_zero;
   assign w_free     = CNT_W'(FIFO_DEPTH) - r_count;
   assign w_push_two = bus.two_req && w_accept && (w_free != '0);
   assign w_push_one = bus.one_req && w_accept && (w_free > CNT_W'(w_push_two));
   assign w_one_slot = r_wr_ptr + PTR_W'(w_push_two);

   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_issue      = 1'b0;
      w_refund     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               if (w_stock_zero) begin
                  w_next_state = S_REFUND;
               end else begin
                  w_pop        = 1'b1;
                  w_issue      = 1'b1;
                  w_next_state = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (w_stock_zero && !w_empty) begin
               w_next_state = S_REFUND;
            end else if (r_gap_cnt == c_GAP_LAST) begin
               w_next_state = S_IDLE;
            end
         end
         S_REFUND: begin
            if (w_empty) begin
               w_next_state = S_IDLE;
            end else begin
               w_pop    = 1'b1;
               w_refund = 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_fifo       <= '0;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
         r_gap_cnt    <= '0;
         r_stock      <= STOCK_W'(INIT_STOCK);
         r_vend       <= '0;
         r_one_in     <= 1'b0;
         r_two_in     <= 1'b0;
         r_refund_one <= 1'b0;
         r_refund_two <= 1'b0;
         r_reject     <= '0;
      end else begin
         r_state   <= w_next_state;
         r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
         if (w_push_two) begin
            r_fifo[r_wr_ptr] <= 1'b1;
         end
         if (w_push_one) begin
            r_fifo[w_one_slot] <= 1'b0;
         end
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_two) + PTR_W'(w_push_one);
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
         r_count  <= r_count + CNT_W'(w_push_two) + CNT_W'(w_push_one) - CNT_W'(w_pop);

         r_one_in     <= w_issue  && !w_head;
         r_two_in     <= w_issue  &&  w_head;
         r_refund_one <= w_refund && !w_head;
         r_refund_two <= w_refund &&  w_head;
         r_reject     <= {bus.two_req && !w_push_two, bus.one_req && !w_push_one};

         if (bus.load_en) begin
            r_stock <= bus.load_val;
         end else if (bus.choco_done && !w_stock_zero) begin
            r_stock <= r_stock - 1'b1;
         end
         if (bus.choco_done && (r_vend != 8'hFF)) begin
            r_vend <= r_vend + 1'b1;
         end
      end
   end

   assign bus.one_in      = r_one_in;
   assign bus.two_in      = r_two_in;
   assign bus.refund_one  = r_refund_one;
   assign bus.refund_two  = r_refund_two;
   assign bus.coin_reject = r_reject;
   assign bus.sold_out    = w_stock_zero;
   assign bus.fifo_count  = r_count;
   assign bus.vend_count  = r_vend;
endmodule
`default_nettype wire

// File: tb/tb_vend_coin_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vend_coin_sequencer : queue-based reference model feeding an event    |
// | scoreboard; monitor pops on every DUT pulse.          Rev 1.0            |
// +--------------------------------------------------------------------------+
module tb_vend_coin_sequencer;
   localparam int FIFO_DEPTH = 4;
   localparam int ISSUE_GAP  = 2;
   localparam int STOCK_W    = 8;
   localparam int INIT_STOCK = 10;

   typedef struct {
      int         cyc;
      logic [5:0] vec;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   ev_t  evq[$];
   bit   mq[$];
   int   m_stock, m_vend, m_cool;
   bit   m_refund;
   int   exp_fifo, exp_vend;
   bit   exp_sold;

   vend_coin_sequencer_if #(.FIFO_DEPTH(FIFO_DEPTH), .STOCK_W(STOCK_W)) vif ();

   vend_coin_sequencer #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .ISSUE_GAP (ISSUE_GAP),
      .STOCK_W   (STOCK_W),
      .INIT_STOCK(INIT_STOCK)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (vif)
   );

   always #5 clk = ~clk;

   // Expected pulse vector: {rej_two, rej_one, two_in, one_in, refund_two, refund_one}.
   task automatic model_step(input bit rn, input bit o, input bit t, input bit ch,
                             input bit ld, input int lv);
      logic [5:0] v;
      int         free;
      bit         acc;
      bit         tok;
      v = '0;
      if (!rn) begin
         mq.delete();
         m_stock  = INIT_STOCK;
         m_vend   = 0;
         m_refund = 1'b0;
         m_cool   = 0;
      end else begin
         acc  = !m_refund && (m_stock != 0);
         free = FIFO_DEPTH - mq.size();
         if (m_refund) begin
            if (mq.size() > 0) begin
               tok = mq.pop_front();
               if (tok) v[1] = 1'b1; else v[0] = 1'b1;
            end else begin
               m_refund = 1'b0;
            end
         end else if (mq.size() > 0 && m_stock == 0) begin
            m_refund = 1'b1;
            m_cool   = 0;
         end else if (mq.size() > 0 && m_cool == 0) begin
            tok = mq.pop_front();
            if (tok) v[3] = 1'b1; else v[2] = 1'b1;
            m_cool = ISSUE_GAP - 1;
         end else if (m_cool > 0) begin
            m_cool--;
         end
         if (t) begin
            if (acc && free > 0) begin mq.push_back(1'b1); free--; end
            else v[5] = 1'b1;
         end
         if (o) begin
            if (acc && free > 0) mq.push_back(1'b0);
            else v[4] = 1'b1;
         end
         if (ld) m_stock = lv;
         else if (ch && m_stock > 0) m_stock--;
         if (ch && m_vend < 255) m_vend++;
      end
      if (v != '0) evq.push_back('{cyc + 1, v});
      exp_fifo = mq.size();
      exp_sold = (m_stock == 0);
      exp_vend = m_vend;
   endtask

   task automatic step(input bit rn, input bit o, input bit t, input bit ch,
                       input bit ld, input int lv);
      @(negedge clk);
      rst_n          = rn;
      vif.one_req    = o;
      vif.two_req    = t;
      vif.choco_done = ch;
      vif.load_en    = ld;
      vif.load_val   = 8'(lv);
      model_step(rn, o, t, ch, ld, lv);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      logic [5:0] vec;
      ev_t        ev;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (chk_en) begin
            vec = {vif.coin_reject, vif.two_in, vif.one_in, vif.refund_two, vif.refund_one};
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
               ev = evq.pop_front();
               checks++; errors++;
               $display("FAIL missing_event cyc=%0d got none, expected vec=%b at cyc %0d", cyc, ev.vec, ev.cyc);
            end
            if (vec != '0) begin
               checks++;
               if (evq.size() == 0 || evq[0].cyc != cyc) begin
                  errors++;
                  $display("FAIL unexpected_event cyc=%0d got vec=%b, expected no pulse", cyc, vec);
               end else begin
                  ev = evq.pop_front();
                  if (ev.vec != vec) begin
                     errors++;
                     $display("FAIL event cyc=%0d got vec=%b, expected %b", cyc, vec, ev.vec);
                  end
               end
            end
            checks++;
            if (vif.one_in && vif.two_in) begin
               errors++;
               $display("FAIL both_coins cyc=%0d got one_in=1 two_in=1, expected at most one", cyc);
            end
            checks++;
            if (int'(vif.fifo_count) != exp_fifo) begin
               errors++;
               $display("FAIL fifo_count cyc=%0d got %0d, expected %0d", cyc, vif.fifo_count, exp_fifo);
            end
            checks++;
            if (vif.sold_out != exp_sold) begin
               errors++;
               $display("FAIL sold_out cyc=%0d got %0b, expected %0b", cyc, vif.sold_out, exp_sold);
            end
            checks++;
            if (int'(vif.vend_count) != exp_vend) begin
               errors++;
               $display("FAIL vend_count cyc=%0d got %0d, expected %0d", cyc, vif.vend_count, exp_vend);
            end
         end
      end
   end

   initial begin : driver
      vif.one_req = 0; vif.two_req = 0; vif.choco_done = 0;
      vif.load_en = 0; vif.load_val = '0;
      step(0, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      // Single two-unit coin, then simultaneous pair.
      step(1, 0, 1, 0, 0, 0);
      idle(4);
      step(1, 1, 1, 0, 0, 0);
      idle(6);
      // Five one-unit strobes in a row plus pairs to overflow the buffer.
      for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(1, 1, 1, 0, 0, 0);
      idle(12);
      // Stock of one, tokens queued, then sell-out with coins arriving during refund.
      step(1, 0, 0, 0, 1, 1);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 1, 4);
      idle(8);
      // Load and dispense in the same cycle.
      step(1, 0, 0, 1, 1, 5);
      idle(2);
      // Reset in the middle of a refund.
      step(1, 0, 0, 0, 1, 1);
      step(1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 0);
      idle(4);
      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), int'($urandom_range(0, 6)));
      end
      // Dispense counter saturation.
      for (int k = 0; k < 260; k++) step(1, 0, 0, 1, 0, 0);
      idle(6);
      checks++;
      if (evq.size() != 0) begin
         errors++;
         $display("FAIL leftover_events got %0d pending, expected 0", evq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
